// File: rtl/jleightcap_pkg.sv
// Shared constants and FSM state encoding for the jleightcap instruction
// fetch front end.
package jleightcap_pkg;

  localparam int IW    = 6;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam logic [IW-1:0] NOP = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/jleightcap_prog_mem.sv
// Program buffer: DEPTH x IW register file with one synchronous write port
// and one combinational read port. Contents survive reset.
module jleightcap_prog_mem #(
  parameter int IW    = jleightcap_pkg::IW,
  parameter int AW    = jleightcap_pkg::AW,
  parameter int DEPTH = jleightcap_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jleightcap_fetch.sv
// Instruction sequencer: loads a short program over valid/ready, then streams
// one registered instruction per clock to the core, following its cjump flag.
module jleightcap_fetch #(
  parameter int IW    = jleightcap_pkg::IW,
  parameter int AW    = jleightcap_pkg::AW,
  parameter int DEPTH = jleightcap_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [IW-1:0]          load_data,
  output logic                   load_ready,
  input  logic                   load_done,
  input  logic                   run,
  input  logic                   loop,
  input  logic                   stop,
  input  logic                   cjump,
  input  logic [AW-1:0]          cjump_target,
  output logic [IW-1:0]          instr,
  output logic                   instr_valid,
  output logic                   halted,
  output logic                   fault,
  output jleightcap_pkg::state_t state
);

  import jleightcap_pkg::*;

  // Load handshake: a word moves when load_valid && load_ready on a rising
  // edge; load_ready is high only in LOAD while the buffer has room.

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  logic [AW-1:0] pc;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   len;
  logic [IW-1:0] rd_data;
  logic          accept;
  logic          last_issue;
  logic          jump_ok;

  jleightcap_prog_mem #(
    .IW    (IW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  assign load_ready = (state == S_LOAD) && (wr_ptr != FULL);
  assign accept     = load_valid && load_ready;
  assign halted     = (state == S_HALT);

  // len is at least 1 whenever RUN is entered, so len - 1 never underflows there.
  assign last_issue = ({1'b0, pc} == (len - LEN_ONE));
  assign jump_ok    = ({1'b0, cjump_target} < len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      wr_ptr      <= '0;
      len         <= '0;
      instr       <= NOP;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          instr       <= NOP;
          instr_valid <= 1'b0;
          if (load_start) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
            fault  <= 1'b0;
          end else if (run && (len != '0)) begin
            state <= S_RUN;
            pc    <= '0;
            fault <= 1'b0;
          end
        end

        S_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + LEN_ONE;
          end
          if (load_done) begin
            state <= S_IDLE;
            len   <= accept ? (wr_ptr + LEN_ONE) : wr_ptr;
          end
        end

        S_RUN: begin
          if (stop) begin
            state       <= S_IDLE;
            instr       <= NOP;
            instr_valid <= 1'b0;
          end else if (cjump) begin
            // The word fetched this cycle is on the wrong path; replace it with a bubble.
            instr       <= NOP;
            instr_valid <= 1'b0;
            if (jump_ok) begin
              pc <= cjump_target;
            end else begin
              fault <= 1'b1;
              state <= S_HALT;
            end
          end else begin
            instr       <= rd_data;
            instr_valid <= 1'b1;
            if (last_issue) begin
              if (loop) begin
                pc <= '0;
              end else begin
                state <= S_HALT;
              end
            end else begin
              pc <= pc + PC_ONE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jleightcap_fetch.sv
// Directed bench for jleightcap_fetch: stimulus queues expected instruction
// words, a forked monitor pops and compares every valid issue.
module tb_jleightcap_fetch;

  import jleightcap_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_ready;
  logic          load_done = 1'b0;
  logic          run = 1'b0;
  logic          loop = 1'b0;
  logic          stop = 1'b0;
  logic          cjump = 1'b0;
  logic [AW-1:0] cjump_target = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          halted;
  logic          fault;
  state_t        state;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] prog [32];

  always #5 clk = ~clk;

  jleightcap_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .run          (run),
    .loop         (loop),
    .stop         (stop),
    .cjump        (cjump),
    .cjump_target (cjump_target),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .fault        (fault),
    .state        (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic monitor;
    logic [IW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (instr_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue: got %0h expected no valid instr (t=%0t)", instr, $time);
          end else begin
            e = exp_q.pop_front();
            check("issue_word", 32'(instr), 32'(e));
          end
        end else begin
          check("nop_when_invalid", 32'(instr), 32'(NOP));
        end
      end
    end
  endtask

  task automatic load_prog(input int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      tick();
    end
    load_valid = 1'b0;
    load_done  = 1'b1;
    tick();
    load_done  = 1'b0;
  endtask

  task automatic expect_words(input int first, input int n);
    for (int i = first; i < first + n; i++) exp_q.push_back(prog[i]);
  endtask

  task automatic run_prog(input logic lp);
    loop = lp;
    run  = 1'b1;
    tick();
    run  = 1'b0;
  endtask

  task automatic stream(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, 32'(instr_valid), 32'(1));
    end
  endtask

  initial begin
    // Reset values while rst is held
    #1;
    check("rst_valid", 32'(instr_valid), 32'(0));
    check("rst_instr", 32'(instr), 32'(NOP));
    check("rst_ready", 32'(load_ready), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_fault", 32'(fault), 32'(0));
    check("rst_state", 32'(state), 32'(S_IDLE));
    tick();
    tick();
    rst = 1'b0;
    fork
      monitor();
    join_none

    // Empty program: run ignored
    run_prog(1'b0);
    tick();
    check("empty_run_state", 32'(state), 32'(S_IDLE));

    // 1: three words, no loop
    prog[0] = 6'h01; prog[1] = 6'h02; prog[2] = 6'h03;
    load_prog(3);
    expect_words(0, 3);
    run_prog(1'b0);
    stream(3, "t1_valid");
    tick();
    check("t1_end_valid", 32'(instr_valid), 32'(0));
    check("t1_halted", 32'(halted), 32'(1));
    check("t1_state", 32'(state), 32'(S_HALT));

    // 2: same program looping, then stop
    expect_words(0, 3);
    expect_words(0, 2);
    run_prog(1'b1);
    check("t2_halt_cleared", 32'(halted), 32'(0));
    stream(5, "t2_valid");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    check("t2_stop_valid", 32'(instr_valid), 32'(0));
    check("t2_stop_state", 32'(state), 32'(S_IDLE));

    // 3: jump back to 0 while word1 is on instr
    prog[0] = 6'h11; prog[1] = 6'h12; prog[2] = 6'h13; prog[3] = 6'h14;
    load_prog(4);
    expect_words(0, 2);
    expect_words(0, 4);
    run_prog(1'b0);
    stream(2, "t3_pre_valid");
    check("t3_word1", 32'(instr), 32'(6'h12));
    cjump = 1'b1;
    cjump_target = 4'd0;
    tick();
    cjump = 1'b0;
    check("t3_bubble", 32'(instr_valid), 32'(0));
    stream(4, "t3_post_valid");
    tick();
    check("t3_halted", 32'(halted), 32'(1));
    check("t3_no_fault", 32'(fault), 32'(0));

    // 4: out-of-range jump faults; cjump in HALT ignored; run clears fault
    expect_words(0, 1);
    run_prog(1'b0);
    stream(1, "t4_pre_valid");
    cjump = 1'b1;
    cjump_target = 4'd5;
    tick();
    cjump = 1'b0;
    check("t4_fault", 32'(fault), 32'(1));
    check("t4_halted", 32'(halted), 32'(1));
    check("t4_valid", 32'(instr_valid), 32'(0));
    cjump = 1'b1;
    cjump_target = 4'd1;
    tick();
    cjump = 1'b0;
    check("t4_halt_cjump_state", 32'(state), 32'(S_HALT));
    expect_words(0, 4);
    run_prog(1'b0);
    check("t4_fault_cleared", 32'(fault), 32'(0));
    check("t4_halt_cleared", 32'(halted), 32'(0));
    stream(4, "t4_rerun_valid");
    tick();
    check("t4_rerun_halted", 32'(halted), 32'(1));

    // 5: 17 words offered back to back; only 16 fit
    for (int i = 0; i < 17; i++) prog[i] = 6'(6'h20 + i);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      check("t5_ready", 32'(load_ready), 32'(i < 16));
      tick();
    end
    load_valid = 1'b0;
    check("t5_full_ready", 32'(load_ready), 32'(0));
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    expect_words(0, 16);
    run_prog(1'b0);
    stream(16, "t5_valid");
    tick();
    check("t5_halted", 32'(halted), 32'(1));

    // 6a: async reset mid-LOAD
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 6'h31;
    tick();
    load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_load_ready", 32'(load_ready), 32'(0));
    check("t6_load_state", 32'(state), 32'(S_IDLE));
    #1;
    rst = 1'b0;
    run_prog(1'b0);
    tick();
    check("t6_run_ignored", 32'(state), 32'(S_IDLE));

    // 6b: async reset mid-RUN
    prog[0] = 6'h31; prog[1] = 6'h32;
    load_prog(2);
    expect_words(0, 1);
    run_prog(1'b1);
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_run_valid", 32'(instr_valid), 32'(0));
    check("t6_run_instr", 32'(instr), 32'(NOP));
    check("t6_run_state", 32'(state), 32'(S_IDLE));
    #1;
    rst = 1'b0;
    run_prog(1'b1);
    tick();
    loop = 1'b0;
    check("t6_rerun_ignored", 32'(state), 32'(S_IDLE));
    check("t6_rerun_valid", 32'(instr_valid), 32'(0));

    // Reload after reset works again
    prog[0] = 6'h3f;
    load_prog(1);
    expect_words(0, 1);
    run_prog(1'b0);
    stream(1, "t6_reload_valid");
    tick();
    check("t6_reload_halted", 32'(halted), 32'(1));

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
